// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
// Shared RV32I types and constants for the MEM-stage load/store unit.
//   rv32i_word / rv32i_reg / rv32i_mem_wmask : datapath, register, byte-mask
//   load_funct3_t / store_funct3_t           : funct3 encodings for loads/stores
//   lsu_state_t                              : load/store unit FSM states
//   WMASK_B / WMASK_H / WMASK_W              : unshifted byte-enable patterns
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

    typedef logic [31:0] rv32i_word;
    typedef logic [4:0]  rv32i_reg;
    typedef logic [3:0]  rv32i_mem_wmask;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_t;

    localparam rv32i_mem_wmask WMASK_B = 4'b0001;
    localparam rv32i_mem_wmask WMASK_H = 4'b0011;
    localparam rv32i_mem_wmask WMASK_W = 4'b1111;

endpackage

// File: rtl/load_store_unit_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
//   funct3     in  : access size (bits 1:0) and unsigned flag (bit 2)
//   offset     in  : byte offset within the word (addr[1:0])
//   store_data in  : rs2 value
//   load_word  in  : raw word returned by memory
//   mask       out : byte enables, shifted to the addressed lanes
//   lane_data  out : store data replicated across all lanes
//   load_data  out : extracted and sign/zero-extended load result
//   misaligned out : halfword at offset 3 or word at non-zero offset
// ---------------------------------------------------------------------------
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]     funct3,
    input  logic [1:0]     offset,
    input  rv32i_word      store_data,
    input  rv32i_word      load_word,
    output rv32i_mem_wmask mask,
    output rv32i_word      lane_data,
    output rv32i_word      load_data,
    output logic           misaligned
);

    // Addressed byte moved down to lane 0; bytes beyond the word end read
    // as zero, so a straddling access only sees its in-word bytes.
    rv32i_word shifted;

    always_comb begin
        shifted    = load_word >> {offset, 3'b000};
        mask       = WMASK_W;
        lane_data  = store_data;
        load_data  = shifted;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                mask      = WMASK_B << offset;
                lane_data = {4{store_data[7:0]}};
                load_data = funct3[2] ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                // Shift result stays 4 bits wide: sh at offset 3 -> 4'b1000.
                mask       = WMASK_H << offset;
                lane_data  = {2{store_data[15:0]}};
                load_data  = funct3[2] ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
                misaligned = (offset == 2'd3);
            end
            default: begin
                mask       = WMASK_W;
                lane_data  = store_data;
                load_data  = shifted;
                misaligned = (offset != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// MEM-stage data-memory interface of the pipelined RV32I core. Takes the
// EX/MEM control word, issues one registered request to data memory, stalls
// the pipeline until the response, and returns extended load data to MEM/WB.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses are refused at accept and reported on err_o.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/read/write       : EX/MEM instruction valid and memory controls
//   req_funct3/addr/wdata/rd   : access size, byte address, rs2, destination
//   flush                      : squash the current instruction
//   stall                      : freeze upstream stages
//   dmem_read/write/address/wdata/byte_enable : registered memory request
//   dmem_resp, dmem_rdata      : memory completion and raw read word
//   wb_valid, wb_rd, wb_data   : one-cycle load result to MEM/WB
//   err_o                      : one-cycle misalign or timeout pulse
// ---------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  rv32i_word         req_wdata,
    input  rv32i_reg          req_rd,
    input  logic              flush,
    output logic              stall,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output rv32i_word         dmem_wdata,
    output rv32i_mem_wmask    dmem_byte_enable,
    input  logic              dmem_resp,
    input  rv32i_word         dmem_rdata,
    output logic              wb_valid,
    output rv32i_reg          wb_rd,
    output rv32i_word         wb_data,
    output logic              err_o
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // Memory handshake: dmem_read/dmem_write and the address/data/mask are
    // registered at accept and held unchanged until the cycle in which memory
    // raises dmem_resp; that cycle completes the transfer, and the request
    // lines drop at the following edge, leaving at least one idle cycle.

    lsu_state_t     state;
    lsu_state_t     state_next;
    logic [2:0]     lat_funct3;
    logic [1:0]     lat_off;
    logic           lat_load;
    rv32i_reg       lat_rd;
    logic           squashed;
    logic [31:0]    to_cnt;

    logic           mem_op;
    logic           trap;
    logic           accept;
    logic           timeout_hit;
    logic [2:0]     sel_funct3;
    logic [1:0]     sel_off;
    rv32i_mem_wmask mask;
    rv32i_word      lane_data;
    rv32i_word      load_data;
    logic           misaligned;

    // In IDLE the aligner sees the incoming request (store lanes, mask,
    // misalign check); in BUSY it sees the latched access for load extraction.
    assign sel_funct3 = (state == BUSY) ? lat_funct3 : req_funct3;
    assign sel_off    = (state == BUSY) ? lat_off    : req_addr[1:0];

    lsu_align u_align (
        .funct3     (sel_funct3),
        .offset     (sel_off),
        .store_data (req_wdata),
        .load_word  (dmem_rdata),
        .mask       (mask),
        .lane_data  (lane_data),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign mem_op = (state == IDLE) && req_valid && (req_read || req_write) && !flush;
    assign trap   = TRAP_EN && mem_op && misaligned;
    assign accept = mem_op && !trap;

    assign timeout_hit = (TIMEOUT_CYC != 0) && (state == BUSY) && !dmem_resp &&
                         (to_cnt == TIMEOUT_CYC - 32'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = BUSY;
            BUSY:    if (dmem_resp) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = accept;
            BUSY:    stall = !dmem_resp;
            default: stall = 1'b0;
        endcase
    end

    // Request, latch and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= '0;
            dmem_wdata       <= '0;
            dmem_byte_enable <= '0;
            lat_funct3       <= '0;
            lat_off          <= '0;
            lat_load         <= 1'b0;
            lat_rd           <= '0;
            squashed         <= 1'b0;
            to_cnt           <= '0;
            wb_valid         <= 1'b0;
            wb_rd            <= '0;
            wb_data          <= '0;
            err_o            <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            err_o    <= trap || timeout_hit;
            if (accept) begin
                // Read wins when both controls are set.
                dmem_read        <= req_read;
                dmem_write       <= req_write && !req_read;
                dmem_address     <= {req_addr[ADDR_W-1:2], 2'b00};
                dmem_wdata       <= lane_data;
                dmem_byte_enable <= mask;
                lat_funct3       <= req_funct3;
                lat_off          <= req_addr[1:0];
                lat_load         <= req_read;
                lat_rd           <= req_rd;
                squashed         <= 1'b0;
                to_cnt           <= '0;
            end else if (state == BUSY) begin
                // A flush cannot abort memory, only the write-back.
                if (flush) squashed <= 1'b1;
                if (dmem_resp) begin
                    dmem_read  <= 1'b0;
                    dmem_write <= 1'b0;
                    if (lat_load && !squashed && !flush) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= lat_rd;
                        wb_data  <= load_data;
                    end
                end else if (to_cnt != TIMEOUT_CYC) begin
                    to_cnt <= to_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main DUT (TIMEOUT_CYC = 0) ----------------
    logic        req_valid, req_read, req_write, flush;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        stall, dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_o;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYC(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .flush(flush), .stall(stall),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable), .dmem_resp(dmem_resp),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .err_o(err_o)
    );

    // ---------------- second DUT (TIMEOUT_CYC = 4) ----------------
    logic        t_req_valid, t_req_read, t_req_write, t_flush;
    logic [2:0]  t_req_funct3;
    logic [31:0] t_req_addr, t_req_wdata;
    logic [4:0]  t_req_rd;
    logic        t_stall, t_dmem_read, t_dmem_write;
    logic [31:0] t_dmem_address, t_dmem_wdata;
    logic [3:0]  t_dmem_byte_enable;
    logic        t_dmem_resp;
    logic [31:0] t_dmem_rdata;
    logic        t_wb_valid;
    logic [4:0]  t_wb_rd;
    logic [31:0] t_wb_data;
    logic        t_err_o;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .req_valid(t_req_valid), .req_read(t_req_read), .req_write(t_req_write),
        .req_funct3(t_req_funct3), .req_addr(t_req_addr), .req_wdata(t_req_wdata),
        .req_rd(t_req_rd), .flush(t_flush), .stall(t_stall),
        .dmem_read(t_dmem_read), .dmem_write(t_dmem_write),
        .dmem_address(t_dmem_address), .dmem_wdata(t_dmem_wdata),
        .dmem_byte_enable(t_dmem_byte_enable), .dmem_resp(t_dmem_resp),
        .dmem_rdata(t_dmem_rdata), .wb_valid(t_wb_valid), .wb_rd(t_wb_rd),
        .wb_data(t_wb_data), .err_o(t_err_o)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    // {check_wdata, read, write, address, wdata, mask}
    logic [70:0] exp_req_q[$];
    // {rd, data}
    logic [36:0] exp_wb_q[$];
    logic [70:0] exp_req;
    logic [70:0] act_req;
    logic [36:0] exp_wb;
    bit          req_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: compares each new memory request and each write-back pulse
    // against the head of the matching expected queue.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            checks++;
            if (exp_wb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected actual rd=%0d data=%h expected no write-back", wb_rd, wb_data);
            end else begin
                exp_wb = exp_wb_q.pop_front();
                if ({wb_rd, wb_data} !== exp_wb) begin
                    errors++;
                    $display("FAIL wb_data actual rd=%0d data=%h expected rd=%0d data=%h",
                             wb_rd, wb_data, exp_wb[36:32], exp_wb[31:0]);
                end
            end
        end
        if ((dmem_read | dmem_write) === 1'b1) begin
            if (!req_seen) begin
                req_seen = 1'b1;
                checks++;
                if (exp_req_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected actual addr=%h rd=%b wr=%b expected no request",
                             dmem_address, dmem_read, dmem_write);
                end else begin
                    exp_req = exp_req_q.pop_front();
                    act_req = {exp_req[70], dmem_read, dmem_write, dmem_address,
                               exp_req[70] ? dmem_wdata : 32'h0, dmem_byte_enable};
                    if (act_req !== exp_req) begin
                        errors++;
                        $display("FAIL mem_req actual rd=%b wr=%b addr=%h wdata=%h mask=%b expected rd=%b wr=%b addr=%h wdata=%h mask=%b",
                                 act_req[69], act_req[68], act_req[67:36], act_req[35:4], act_req[3:0],
                                 exp_req[69], exp_req[68], exp_req[67:36], exp_req[35:4], exp_req[3:0]);
                    end
                end
            end
        end else begin
            req_seen = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // One complete transaction: accept, wait_cyc BUSY cycles without resp,
    // then a resp cycle. flush_busy pulses flush in the first BUSY cycle.
    task automatic do_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input int wait_cyc, input logic [31:0] rdata, input logic flush_busy,
                         input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_wb_data);
        int stall_cnt;
        @(negedge clk);
        check("port_idle", {30'h0, dmem_read, dmem_write}, 32'h0);
        check("err_quiet", {31'h0, err_o}, 32'h0);
        req_valid  = 1'b1;
        req_read   = rd_en;
        req_write  = wr_en;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_rd     = rd;
        exp_req_q.push_back({!rd_en, rd_en, wr_en & !rd_en, exp_addr,
                             rd_en ? 32'h0 : exp_wdata, exp_mask});
        if (rd_en && !flush_busy) exp_wb_q.push_back({rd, exp_wb_data});
        #1 check("stall_accept", {31'h0, stall}, 32'h1);
        stall_cnt = (stall === 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
        for (int i = 0; i < wait_cyc; i++) begin
            @(negedge clk);
            flush = flush_busy && (i == 0);
            #1;
            if (stall === 1'b1) stall_cnt++;
        end
        @(negedge clk);
        flush      = 1'b0;
        dmem_resp  = 1'b1;
        dmem_rdata = rdata;
        #1 check("stall_resp", {31'h0, stall}, 32'h0);
        check("stall_cycles", stall_cnt, wait_cyc + 1);
        @(posedge clk);
        #1;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    // ---------------- stimulus ----------------
    int seen_at;
    int err_pulses;

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_read = 0; req_write = 0; req_funct3 = 0;
        req_addr = 0; req_wdata = 0; req_rd = 0; flush = 0;
        dmem_resp = 0; dmem_rdata = 0;
        t_req_valid = 0; t_req_read = 0; t_req_write = 0; t_req_funct3 = 0;
        t_req_addr = 0; t_req_wdata = 0; t_req_rd = 0; t_flush = 0;
        t_dmem_resp = 0; t_dmem_rdata = 0;

        repeat (2) @(negedge clk);
        check("rst_read",  {31'h0, dmem_read}, 32'h0);
        check("rst_write", {31'h0, dmem_write}, 32'h0);
        check("rst_addr",  dmem_address, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_mask",  {28'h0, dmem_byte_enable}, 32'h0);
        check("rst_wb",    {26'h0, wb_valid, wb_rd}, 32'h0);
        check("rst_wbdata", wb_data, 32'h0);
        check("rst_err",   {31'h0, err_o}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        rst_n = 1'b1;

        //    rd wr f3      addr          wdata          rd wait rdata          fl exp_addr    mask  exp_wdata      exp_wb
        do_op(1, 0, 3'b010, 32'h100,      32'h0,         5, 2,   32'hDEADBEEF,  0, 32'h100,    4'hF, 32'h0,         32'hDEADBEEF);
        do_op(1, 0, 3'b000, 32'h103,      32'h0,         6, 0,   32'h80FFFFFF,  0, 32'h100,    4'h8, 32'h0,         32'hFFFFFF80);
        do_op(1, 0, 3'b100, 32'h103,      32'h0,         7, 1,   32'h80FFFFFF,  0, 32'h100,    4'h8, 32'h0,         32'h00000080);
        do_op(0, 1, 3'b001, 32'h202,      32'h1234ABCD,  0, 1,   32'h0,         0, 32'h200,    4'hC, 32'hABCDABCD,  32'h0);
        // back-to-back sw then lw, resp in the first BUSY cycle
        do_op(0, 1, 3'b010, 32'h300,      32'hCAFEF00D,  0, 0,   32'h0,         0, 32'h300,    4'hF, 32'hCAFEF00D,  32'h0);
        do_op(1, 0, 3'b010, 32'h304,      32'h0,         8, 0,   32'h11223344,  0, 32'h304,    4'hF, 32'h0,         32'h11223344);
        do_op(1, 0, 3'b001, 32'h102,      32'h0,         9, 0,   32'h80011234,  0, 32'h100,    4'hC, 32'h0,         32'hFFFF8001);
        do_op(1, 0, 3'b101, 32'h102,      32'h0,        10, 0,   32'h80011234,  0, 32'h100,    4'hC, 32'h0,         32'h00008001);
        do_op(1, 0, 3'b001, 32'h100,      32'h0,        15, 1,   32'h80011234,  0, 32'h100,    4'h3, 32'h0,         32'h00001234);
        do_op(1, 0, 3'b000, 32'h101,      32'h0,        16, 0,   32'h80011234,  0, 32'h100,    4'h2, 32'h0,         32'h00000012);
        do_op(0, 1, 3'b000, 32'h401,      32'h000000A5,  0, 0,   32'h0,         0, 32'h400,    4'h2, 32'hA5A5A5A5,  32'h0);
        // read and write together: the read wins
        do_op(1, 1, 3'b010, 32'h500,      32'h99999999, 11, 0,   32'h0BADF00D,  0, 32'h500,    4'hF, 32'h0,         32'h0BADF00D);
        // flush during BUSY: memory completes, no write-back
        do_op(1, 0, 3'b010, 32'h510,      32'h0,        12, 2,   32'h12345678,  1, 32'h510,    4'hF, 32'h0,         32'h0);
`ifndef LSU_MISALIGN_TRAP_EN
        do_op(0, 1, 3'b001, 32'h203,      32'h1234ABCD,  0, 0,   32'h0,         0, 32'h200,    4'h8, 32'hABCDABCD,  32'h0);
        do_op(1, 0, 3'b010, 32'h101,      32'h0,        13, 0,   32'hDEADBEEF,  0, 32'h100,    4'hF, 32'h0,         32'h00DEADBE);
        do_op(1, 0, 3'b001, 32'h103,      32'h0,        14, 0,   32'h80123456,  0, 32'h100,    4'h8, 32'h0,         32'h00000080);
`else
        // misaligned lw: refused, err_o pulses next cycle
        @(negedge clk);
        req_valid = 1; req_read = 1; req_funct3 = 3'b010; req_addr = 32'h101; req_rd = 5'd13;
        #1 check("trap_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1 req_valid = 0; req_read = 0;
        @(negedge clk);
        check("trap_err", {31'h0, err_o}, 32'h1);
        check("trap_no_req", {30'h0, dmem_read, dmem_write}, 32'h0);
        @(negedge clk);
        check("trap_err_pulse", {31'h0, err_o}, 32'h0);
`endif

        // non-memory instruction and flush in the accept cycle are ignored
        @(negedge clk);
        req_valid = 1; req_read = 0; req_write = 0;
        #1 check("nonmem_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        check("nonmem_no_req", {30'h0, dmem_read, dmem_write}, 32'h0);
        req_read = 1; req_funct3 = 3'b010; req_addr = 32'h520; flush = 1;
        #1 check("flush_accept_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        check("flush_accept_no_req", {30'h0, dmem_read, dmem_write}, 32'h0);
        req_valid = 0; req_read = 0; flush = 0;

        // reset mid-BUSY: request drops at once, late resp ignored
        @(negedge clk);
        req_valid = 1; req_read = 1; req_funct3 = 3'b010; req_addr = 32'h600; req_rd = 5'd20;
        exp_req_q.push_back({1'b0, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF});
        @(posedge clk);
        #1 req_valid = 0; req_read = 0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async_read", {31'h0, dmem_read}, 32'h0);
        check("rst_async_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        dmem_resp = 1; dmem_rdata = 32'h77777777;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 dmem_resp = 0; dmem_rdata = 0;
        repeat (2) @(negedge clk);
        check("rst_late_resp_port", {30'h0, dmem_read, dmem_write}, 32'h0);

        // timeout on the TIMEOUT_CYC=4 instance
        @(negedge clk);
        t_req_valid = 1; t_req_read = 1; t_req_funct3 = 3'b010; t_req_addr = 32'h700; t_req_rd = 5'd7;
        @(posedge clk);
        #1 t_req_valid = 0; t_req_read = 0;
        seen_at = 0;
        err_pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (t_err_o === 1'b1) begin
                err_pulses++;
                if (seen_at == 0) seen_at = k;
            end
        end
        check("timeout_cycle", seen_at, 5);
        check("timeout_pulses", err_pulses, 1);
        check("timeout_still_busy", {30'h0, t_stall, t_dmem_read}, 32'h3);
        t_dmem_resp = 1; t_dmem_rdata = 32'h55;
        @(posedge clk);
        #1 t_dmem_resp = 0; t_dmem_rdata = 0;
        @(negedge clk);
        check("timeout_wb_valid", {31'h0, t_wb_valid}, 32'h1);
        check("timeout_wb_data", t_wb_data, 32'h55);

        repeat (3) @(negedge clk);
        check("wb_queue_empty", exp_wb_q.size(), 0);
        check("req_queue_empty", exp_req_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
